ex_ma_skid_reg: RTL and testbench
=================================

// Module: ex_ma_skid_reg
// PURPOSE
//  Parametrised EX->MA pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
//  Sits between execute and memory-access stages; absorbs one-cycle downstream back-pressure without
//  combinational ready paths. Also exports an ALU-result forwarding tap from the output entry.
// PARAMETERS
//  NBITS   32  datapath width of ALU result and effective address
//  REG_AW  5   register-index width (rd, rt)
//  CNT_W   16  stall-counter width (used only with EX_MA_STALL_CNT_EN)
// PORTS
//  i_clk            in   1       clock, all state on rising edge
//  i_rst_n          in   1       synchronous reset, active low
//  i_flush          in   1       sync flush: drop all held entries
//  i_valid          in   1       EX presents an entry
//  o_ready          out  1       buffer can accept (registered)
//  i_pc_mux_ctrl    in   1       payload: PC mux control
//  i_ALU_rslt       in   NBITS   payload: ALU result
//  i_eff_addr       in   NBITS   payload: effective address
//  i_flg_mem_op     in   1       payload: 1 = load/store
//  i_flg_mem_type   in   1       payload: 0 = load, 1 = store
//  i_flg_mem_size   in   2       payload: access size
//  i_flg_unsign     in   1       payload: unsigned load
//  i_rd, i_rt       in   REG_AW  payload: register indices
//  i_flg_ALU_dst    in   1       payload: 1 = dest rd, 0 = dest rt
//  o_valid          out  1       MA-side entry valid
//  i_ready          in   1       MA accepts
//  o_<payload>      out  as in   registered payload of output entry (same names, o_ prefix)
//  o_fwd_en         out  1       forwarding tap valid
//  o_fwd_reg        out  REG_AW  forwarding destination index
//  o_fwd_data       out  NBITS   forwarding data (= o_ALU_rslt)
//  o_stall_cnt      out  CNT_W   stall cycles (only with EX_MA_STALL_CNT_EN)
// BEHAVIOUR
//  - in_fire = i_valid & o_ready; out_fire = o_valid & i_ready. Two regs: MAIN (drives outputs), SKID.
//  - States: EMPTY (none valid), ONE (MAIN valid), FULL (MAIN+SKID valid). o_ready = (state != FULL).
//  - EMPTY: in_fire -> ONE, MAIN<=input.
//  - ONE: in_fire&out_fire -> ONE, MAIN<=input; in_fire&!out_fire -> FULL, SKID<=input;
//    !in_fire&out_fire -> EMPTY; else hold.
//  - FULL: out_fire -> ONE, MAIN<=SKID; else hold. No input accepted (o_ready=0).
//  - Latency: 1 cycle input->o_valid when EMPTY; entries leave strictly in order, none dropped/duplicated.
//  - Payload stable while o_valid & !i_ready; o_valid never deasserts without out_fire except flush/reset.
//  - When o_valid=0 all o_ payload outputs and fwd outputs read 0.
//  - Flush: next state EMPTY, MAIN/SKID payload zeroed; flush wins over simultaneous in_fire/out_fire.
//  - Reset (i_rst_n=0 at edge): state EMPTY, all outputs 0 except o_ready=1, o_stall_cnt=0.
//    Reset mid-FULL discards both entries.
//  - Forwarding: dst = o_flg_ALU_dst ? o_rd : o_rt;
//    o_fwd_en = o_valid & !o_flg_mem_op & (dst != 0); o_fwd_reg = o_fwd_en ? dst : 0.
//  - No arithmetic on payload; widths passed through unchanged.
// CONFIGURATION
//  EX_MA_STALL_CNT_EN defined: o_stall_cnt increments each cycle o_valid & !i_ready,
//    saturates at all-ones, cleared only by reset (not flush).
//  Not defined: o_stall_cnt port and counter logic absent; all other behaviour identical.
// TESTING
//  1 Reset: hold i_rst_n=0 2 cycles w/ i_valid=1 -> o_valid=0, o_ready=1, outputs 0.
//  2 Streaming: i_ready=1, 8 entries ALU_rslt=1..8 back-to-back -> o_ALU_rslt 1..8 on cycles 1..8, o_ready stays 1.
//  3 Back-pressure: send A=0xA,B=0xB with i_ready=0 -> FULL, o_ready=0, o_ALU_rslt=0xA held;
//    i_ready=1 -> 0xA then 0xB, o_ready=1 after first out_fire.
//  4 Flush in FULL with i_valid=1 same cycle -> next cycle o_valid=0, o_ready=1, new entry not captured.
//  5 Forward: ALU op rd=5,ALU_dst=1,rslt=0x1234 -> o_fwd_en=1,o_fwd_reg=5,o_fwd_data=0x1234;
//    load or dst=0 -> o_fwd_en=0.
//  6 (EX_MA_STALL_CNT_EN, CNT_W=4) hold o_valid=1,i_ready=0 for 20 cycles -> o_stall_cnt=15; flush keeps 15.

Source files
------------

// File: rtl/ex_ma_skid_reg.sv
// EX->MA pipeline register: valid/ready handshake, 2-entry skid buffer, flush and ALU forwarding tap.
// Optional stall counter enabled by defining EX_MA_STALL_CNT_EN.
module ex_ma_skid_reg #(
  parameter int NBITS  = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_pc_mux_ctrl,
  input  logic [NBITS-1:0]  i_ALU_rslt,
  input  logic [NBITS-1:0]  i_eff_addr,
  input  logic              i_flg_mem_op,
  input  logic              i_flg_mem_type,
  input  logic [1:0]        i_flg_mem_size,
  input  logic              i_flg_unsign,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [REG_AW-1:0] i_rt,
  input  logic              i_flg_ALU_dst,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_pc_mux_ctrl,
  output logic [NBITS-1:0]  o_ALU_rslt,
  output logic [NBITS-1:0]  o_eff_addr,
  output logic              o_flg_mem_op,
  output logic              o_flg_mem_type,
  output logic [1:0]        o_flg_mem_size,
  output logic              o_flg_unsign,
  output logic [REG_AW-1:0] o_rd,
  output logic [REG_AW-1:0] o_rt,
  output logic              o_flg_ALU_dst,
  output logic              o_fwd_en,
  output logic [REG_AW-1:0] o_fwd_reg,
  output logic [NBITS-1:0]  o_fwd_data
`ifdef EX_MA_STALL_CNT_EN
  ,output logic [CNT_W-1:0] o_stall_cnt
`endif
);

  typedef struct packed {
    logic              pc_mux_ctrl;
    logic [NBITS-1:0]  alu_rslt;
    logic [NBITS-1:0]  eff_addr;
    logic              mem_op;
    logic              mem_type;
    logic [1:0]        mem_size;
    logic              unsign;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rt;
    logic              alu_dst;
  } pay_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  state_e state_q, state_d;
  pay_t   main_q, main_d;
  pay_t   skid_q, skid_d;
  pay_t   in_pay, out_pay;
  logic   in_fire, out_fire;
  logic [REG_AW-1:0] dst;

  assign in_pay = '{pc_mux_ctrl: i_pc_mux_ctrl, alu_rslt: i_ALU_rslt, eff_addr: i_eff_addr,
                    mem_op: i_flg_mem_op, mem_type: i_flg_mem_type, mem_size: i_flg_mem_size,
                    unsign: i_flg_unsign, rd: i_rd, rt: i_rt, alu_dst: i_flg_ALU_dst};

  // Handshake flags come straight from registered state: no comb path from i_ready to o_ready.
  assign o_valid  = (state_q != S_EMPTY);
  assign o_ready  = (state_q != S_FULL);
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: if (in_fire) begin
        state_d = S_ONE;
        main_d  = in_pay;
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_pay;
        end else if (in_fire) begin
          state_d = S_FULL;
          skid_d  = in_pay;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: if (out_fire) begin
        state_d = S_ONE;
        main_d  = skid_q;
      end
      default: state_d = S_EMPTY;
    endcase
    if (i_flush) begin
      state_d = S_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // MAIN may keep a stale payload after draining; mask it so idle outputs read zero.
  assign out_pay = o_valid ? main_q : '0;

  assign o_pc_mux_ctrl  = out_pay.pc_mux_ctrl;
  assign o_ALU_rslt     = out_pay.alu_rslt;
  assign o_eff_addr     = out_pay.eff_addr;
  assign o_flg_mem_op   = out_pay.mem_op;
  assign o_flg_mem_type = out_pay.mem_type;
  assign o_flg_mem_size = out_pay.mem_size;
  assign o_flg_unsign   = out_pay.unsign;
  assign o_rd           = out_pay.rd;
  assign o_rt           = out_pay.rt;
  assign o_flg_ALU_dst  = out_pay.alu_dst;

  assign dst        = out_pay.alu_dst ? out_pay.rd : out_pay.rt;
  assign o_fwd_en   = o_valid & ~out_pay.mem_op & (dst != '0);
  assign o_fwd_reg  = o_fwd_en ? dst : '0;
  assign o_fwd_data = out_pay.alu_rslt;

`ifdef EX_MA_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating; flush deliberately leaves it alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_valid && !i_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  logic [CNT_W-1:0] unused_stall_cnt;
  assign unused_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_ma_skid_reg.sv
// Bench for ex_ma_skid_reg: directed scenarios plus random traffic against a queue model.
module tb_ex_ma_skid_reg;
  localparam int NBITS  = 32;
  localparam int REG_AW = 5;
`ifdef EX_MA_STALL_CNT_EN
  localparam int CNT_W  = 4;
`else
  localparam int CNT_W  = 16;
`endif

  typedef struct packed {
    logic              pcm;
    logic [NBITS-1:0]  alu;
    logic [NBITS-1:0]  addr;
    logic              mop;
    logic              mtyp;
    logic [1:0]        msz;
    logic              uns;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rt;
    logic              adst;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n, flush, vin, rdy_in;
  ent_t din;
  logic vout, rdy_out, o_pcm, o_mop, o_mtyp, o_uns, o_adst, fwd_en;
  logic [1:0] o_msz;
  logic [NBITS-1:0] o_alu, o_addr, fwd_data;
  logic [REG_AW-1:0] o_rd, o_rt, fwd_reg;
`ifdef EX_MA_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  int m_stall = 0;
`endif

  int n_cmp = 0, n_bad = 0;
  ent_t mq[$];

  always #5 clk = ~clk;

  ex_ma_skid_reg #(.NBITS(NBITS), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(vin), .o_ready(rdy_out),
    .i_pc_mux_ctrl(din.pcm), .i_ALU_rslt(din.alu), .i_eff_addr(din.addr),
    .i_flg_mem_op(din.mop), .i_flg_mem_type(din.mtyp), .i_flg_mem_size(din.msz),
    .i_flg_unsign(din.uns), .i_rd(din.rd), .i_rt(din.rt), .i_flg_ALU_dst(din.adst),
    .o_valid(vout), .i_ready(rdy_in),
    .o_pc_mux_ctrl(o_pcm), .o_ALU_rslt(o_alu), .o_eff_addr(o_addr),
    .o_flg_mem_op(o_mop), .o_flg_mem_type(o_mtyp), .o_flg_mem_size(o_msz),
    .o_flg_unsign(o_uns), .o_rd(o_rd), .o_rt(o_rt), .o_flg_ALU_dst(o_adst),
    .o_fwd_en(fwd_en), .o_fwd_reg(fwd_reg), .o_fwd_data(fwd_data)
`ifdef EX_MA_STALL_CNT_EN
    ,.o_stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.pcm  = 1'($urandom);
    e.alu  = $urandom;
    e.addr = $urandom;
    e.mop  = 1'($urandom);
    e.mtyp = 1'($urandom);
    e.msz  = 2'($urandom);
    e.uns  = 1'($urandom);
    e.rd   = REG_AW'($urandom);
    e.rt   = REG_AW'($urandom);
    e.adst = 1'($urandom);
    return e;
  endfunction

  // Compare every DUT output with what the queue model says should be at the head.
  task automatic check_all();
    ent_t e;
    logic ev, fen;
    logic [REG_AW-1:0] d;
    ev = (mq.size() > 0);
    e  = ev ? mq[0] : '0;
    d  = e.adst ? e.rd : e.rt;
    fen = ev && !e.mop && (d != 0);
    chk("valid", 64'(vout), 64'(ev));
    chk("ready", 64'(rdy_out), 64'(mq.size() < 2));
    chk("alu",   64'(o_alu), 64'(e.alu));
    chk("addr",  64'(o_addr), 64'(e.addr));
    chk("ctl",   64'({o_pcm, o_mop, o_mtyp, o_msz, o_uns, o_adst}),
                 64'({e.pcm, e.mop, e.mtyp, e.msz, e.uns, e.adst}));
    chk("rd_rt", 64'({o_rd, o_rt}), 64'({e.rd, e.rt}));
    chk("fwd_en",   64'(fwd_en), 64'(fen));
    chk("fwd_reg",  64'(fwd_reg), 64'(fen ? d : '0));
    chk("fwd_data", 64'(fwd_data), 64'(e.alu));
`ifdef EX_MA_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  // One clock: inputs already driven; model advances at the edge, outputs checked at negedge.
  task automatic cycle();
    logic inf, outf;
    @(posedge clk);
    inf  = vin && (mq.size() < 2);
    outf = (mq.size() > 0) && rdy_in;
`ifdef EX_MA_STALL_CNT_EN
    if (!rst_n) m_stall = 0;
    else if (mq.size() > 0 && !rdy_in && m_stall < (1 << CNT_W) - 1) m_stall++;
`endif
    if (!rst_n || flush) mq.delete();
    else begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(din);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic v, input logic r, input logic f, input ent_t e);
    vin = v; rdy_in = r; flush = f; din = e;
  endtask

  initial begin
    ent_t e;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, rnd_ent());
    @(negedge clk);
    // Reset held with valid input present
    repeat (2) cycle();
    chk("rst_valid", 64'(vout), 64'd0);
    chk("rst_ready", 64'(rdy_out), 64'd1);
    rst_n = 1'b1;

    // Streaming 1..8 back-to-back
    for (int k = 1; k <= 8; k++) begin
      e = rnd_ent(); e.alu = k;
      drive(1'b1, 1'b1, 1'b0, e);
      cycle();
      chk("stream_alu", 64'(o_alu), 64'(k));
      chk("stream_rdy", 64'(rdy_out), 64'd1);
    end
    drive(1'b0, 1'b1, 1'b0, '0);
    cycle();

    // Back-pressure: A, B with i_ready=0 -> FULL
    e = rnd_ent(); e.alu = 32'hA; drive(1'b1, 1'b0, 1'b0, e); cycle();
    e = rnd_ent(); e.alu = 32'hB; drive(1'b1, 1'b0, 1'b0, e); cycle();
    e = rnd_ent(); e.alu = 32'hC; drive(1'b1, 1'b0, 1'b0, e); cycle();
    chk("bp_full_rdy", 64'(rdy_out), 64'd0);
    chk("bp_hold_a", 64'(o_alu), 64'hA);
    drive(1'b0, 1'b1, 1'b0, '0); cycle();
    chk("bp_b", 64'(o_alu), 64'hB);
    chk("bp_rdy", 64'(rdy_out), 64'd1);
    cycle();
    chk("bp_empty", 64'(vout), 64'd0);

    // Fill then flush with a simultaneous valid input
    e = rnd_ent(); drive(1'b1, 1'b0, 1'b0, e); cycle(); cycle();
    chk("fl_full", 64'(rdy_out), 64'd0);
    drive(1'b1, 1'b1, 1'b1, rnd_ent()); cycle();
    chk("fl_valid", 64'(vout), 64'd0);
    chk("fl_ready", 64'(rdy_out), 64'd1);
    drive(1'b0, 1'b1, 1'b0, '0); cycle();
    chk("fl_nocap", 64'(vout), 64'd0);

    // Forwarding: ALU op to rd=5, then a load, then dst=0
    e = '0; e.alu = 32'h1234; e.rd = 5; e.adst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, e); cycle();
    chk("fwd_en5", 64'(fwd_en), 64'd1);
    chk("fwd_reg5", 64'(fwd_reg), 64'd5);
    chk("fwd_dat5", 64'(fwd_data), 64'h1234);
    e.mop = 1'b1; drive(1'b1, 1'b1, 1'b0, e); cycle();
    chk("fwd_load", 64'(fwd_en), 64'd0);
    e.mop = 1'b0; e.adst = 1'b0; e.rt = 0; drive(1'b1, 1'b1, 1'b0, e); cycle();
    chk("fwd_r0", 64'(fwd_en), 64'd0);
    drive(1'b0, 1'b1, 1'b0, '0); cycle();

`ifdef EX_MA_STALL_CNT_EN
    rst_n = 1'b0; drive(1'b0, 1'b1, 1'b0, '0); cycle(); rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, rnd_ent()); cycle();
    drive(1'b0, 1'b0, 1'b0, '0);
    repeat (20) cycle();
    chk("stall_sat", 64'(stall_cnt), 64'd15);
    drive(1'b0, 1'b0, 1'b1, '0); cycle();
    chk("stall_flush", 64'(stall_cnt), 64'd15);
`endif

    // Random traffic including occasional flush and reset
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 40) == 0), rnd_ent());
      rst_n = ($urandom_range(0, 80) != 0);
      cycle();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
